sync_ising_matrix: RTL and testbench
====================================

SYNC_ISING_MATRIX -- requirements
Module: sync_ising_matrix

Interface
REQ-001 SHALL have parameter N, default 8, spin count; power of two, 2..32.
REQ-002 SHALL have parameter WEIGHT_W, default 4, signed coupling width; range -2^(WEIGHT_W-1)..2^(WEIGHT_W-1)-1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic on rising edge; axi_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port start  in  1  run request, sampled in IDLE only.
REQ-005 SHALL have port sweeps  in  16  number of full sweeps S, latched at start.
REQ-006 SHALL have ports busy  out  1, run in progress; done  out  1, one-cycle completion pulse.
REQ-007 SHALL have port spins  out  N  current spin state; bit=1 means +1, bit=0 means -1.
REQ-008 SHALL have ports wready  in  1; wr_addr  in  32; wdata  in  32; rd_addr  in  32; rdata  out  32.

Function
REQ-009 SHALL decode i = addr[2 +: log2(N)] and j = addr[13 +: log2(N)]; any set bit in addr[12:2] or addr[23:13] above the index is out-of-range.
REQ-010 SHALL write J[i][j] = wdata[WEIGHT_W-1:0] when wready, wr_addr[31:24]==`WEIGHT_ADDR_MASK, in range and not busy.
REQ-011 SHALL write spins = wdata[N-1:0] when wready, wr_addr[31:24]==`SPIN_ADDR_MASK (defined in defines.vh) and not busy.
REQ-012 SHALL ignore writes while busy, and out-of-range or unmatched writes.
REQ-013 SHALL register rdata one cycle after rd_addr: sign-extended J[i][j] for weight mask, zero-extended spins for spin mask, 0 otherwise.
REQ-014 SHALL implement FSM IDLE, ACCUM, UPDATE, DONE; busy=1 exactly in ACCUM and UPDATE; done=1 exactly in DONE.
REQ-015 SHALL, on the edge sampling start in IDLE (edge 0), latch S and enter ACCUM with i=0, j=0, h=0, or DONE if S==0.
REQ-016 SHALL in ACCUM add +J[i][j] if spins[j]=1, -J[i][j] if 0, skipping j==i, one j per cycle; after j=N-1 go to UPDATE.
REQ-017 SHALL size accumulator h at WEIGHT_W+log2(N)+1 bits signed, no overflow possible.
REQ-018 SHALL in UPDATE set spins[i]=1 if h>0, 0 if h<0, tie rule of REQ-024/025 if h==0, using already-updated spins for later i.
REQ-019 SHALL advance i, wrapping to 0 and incrementing sweep count; after sweep S go to DONE, else ACCUM with h cleared.
REQ-020 SHALL enter DONE at edge S*N*(N+1) counted from edge 0, hold it one cycle, then return to IDLE.
REQ-021 SHALL ignore start while busy or in DONE.

Reset
REQ-022 SHALL on axi_rst clear all J to 0, spins to 0, rdata to 0, busy/done to 0, counters to 0, FSM to IDLE; applies mid-run, no done pulse.

Configuration
REQ-023 SHALL honour macro SYNC_ISING_RANDOM_TIE_EN.
REQ-024 SHALL, with the macro defined, include a 16-bit maximal LFSR, seed 16'hACE1 on reset, stepping once per UPDATE; on h==0 set spins[i] = LFSR bit 0.
REQ-025 SHALL, with the macro undefined, contain no LFSR; on h==0 leave spins[i] unchanged.

Verification
REQ-026 Reset: assert axi_rst 2 cycles -> spins=0, busy=0, done=0, rdata=0, weight readback 0.
REQ-027 Weight R/W: write J[0][1]=3, then -5 -> rdata 0x00000003, then 0xFFFFFFFB, one cycle after rd_addr; write with j field bit above log2(N) -> no change.
REQ-028 Ferromagnet: N=4, all off-diagonal J=+1, spins=4'b0111, S=1 -> done in cycle after edge 20, spins=4'b1111; spins=4'b0001 -> 4'b0000.
REQ-029 Tie, macro undefined: N=4, all J=0, spins=4'b1010, S=2 -> done after edge 40, spins=4'b1010, busy high edges 0..39.
REQ-030 S=0 and start during busy: S=0 -> done in cycle right after edge 0, spins unchanged; second start pulse mid-run -> ignored, single done.
REQ-031 Reset mid-run: axi_rst at edge 7 of an S=1 run -> next cycle busy=0, spins=0, no done pulse; weight write during busy -> readback unchanged.

Source files
------------

// File: rtl/sync_ising_matrix.sv
// sync_ising_matrix: Ising-model spin annealer. Holds an NxN signed coupling
// matrix and an N-bit spin vector. Both are loaded through a simple register
// port. A run performs S full sequential sweeps. In each sweep, every spin
// takes the sign of its local field h_i = sum_j J[i][j]*s_j, for j != i.
// Optional feature: define SYNC_ISING_RANDOM_TIE_EN to break h==0 ties with
// a 16-bit LFSR. Without it, a tie leaves the spin unchanged.
// Address-space selectors WEIGHT_ADDR_MASK / SPIN_ADDR_MASK normally come from
// the project-wide defines header; the fallbacks below apply when they do not.

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'h01
`endif
`ifndef SPIN_ADDR_MASK
`define SPIN_ADDR_MASK 8'h02
`endif

module sync_ising_matrix #(
    parameter int N        = 8,
    parameter int WEIGHT_W = 4
) (
    input  logic          clk,
    input  logic          axi_rst,
    input  logic          start,
    input  logic [15:0]   sweeps,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  spins,
    input  logic          wready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rdata
);

    localparam int LW  = $clog2(N);
    localparam int HW  = WEIGHT_W + LW + 1;   // |h| <= (N-1)*2^(WEIGHT_W-1), never overflows
    localparam int MEM = N * N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic signed [WEIGHT_W-1:0] weight_mem [MEM];
    logic [N-1:0]               spins_reg;
    logic [LW-1:0]              i_reg, j_reg;
    logic signed [HW-1:0]       h_reg;
    logic [15:0]                sweep_cnt_reg;
    logic [15:0]                sweeps_reg;
    logic [31:0]                rdata_reg;

    // ---------------- address decode ----------------
    logic [LW-1:0] wr_i, wr_j, rd_i, rd_j;
    logic          wr_in_range, rd_in_range;
    logic          weight_we, spin_we;

    assign wr_i = wr_addr[2 +: LW];
    assign wr_j = wr_addr[13 +: LW];
    assign rd_i = rd_addr[2 +: LW];
    assign rd_j = rd_addr[13 +: LW];

    // Any index-field bit above log2(N) makes the address point outside the matrix.
    assign wr_in_range = ((wr_addr[12:2] >> LW) == 11'd0) && ((wr_addr[23:13] >> LW) == 11'd0);
    assign rd_in_range = ((rd_addr[12:2] >> LW) == 11'd0) && ((rd_addr[23:13] >> LW) == 11'd0);

    assign weight_we = wready && !busy && wr_in_range && (wr_addr[31:24] == `WEIGHT_ADDR_MASK);
    assign spin_we   = wready && !busy && (wr_addr[31:24] == `SPIN_ADDR_MASK);

    // Address LSBs and wdata bits beyond the field widths carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{wdata, wr_addr[1:0], rd_addr[1:0]};

    // ---------------- datapath helpers ----------------
    logic signed [WEIGHT_W-1:0] w_cur;
    logic signed [HW-1:0]       w_ext;
    logic signed [HW-1:0]       term;
    logic                       j_last, i_last, sweep_last;
    logic                       tie_bit;
    logic                       new_spin;

    assign w_cur      = weight_mem[{i_reg, j_reg}];
    assign w_ext      = HW'(w_cur);
    assign term       = spins_reg[j_reg] ? w_ext : -w_ext;
    assign j_last     = (j_reg == LW'(N - 1));
    assign i_last     = (i_reg == LW'(N - 1));
    assign sweep_last = (sweep_cnt_reg == (sweeps_reg - 16'd1));

`ifdef SYNC_ISING_RANDOM_TIE_EN
    logic [15:0] lfsr_reg;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per spin update.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (state_reg == ST_UPDATE) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign tie_bit = lfsr_reg[0];
`else
    assign tie_bit = spins_reg[i_reg];
`endif

    assign new_spin = (h_reg == '0) ? tie_bit : !h_reg[HW-1];

    // ---------------- coupling matrix ----------------
    // Coupling storage: cleared on reset, written only while idle or done.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            for (int k = 0; k < MEM; k++) begin
                weight_mem[k] <= '0;
            end
        end else if (weight_we) begin
            weight_mem[{wr_i, wr_j}] <= wdata[WEIGHT_W-1:0];
        end
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (sweeps == 16'd0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (j_last) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_next = (i_last && sweep_last) ? ST_DONE : ST_ACCUM;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg == ST_ACCUM) || (state_reg == ST_UPDATE);
    assign done = (state_reg == ST_DONE);

    // Run counters and local-field accumulator: one j per ACCUM cycle, then a spin update.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            i_reg         <= '0;
            j_reg         <= '0;
            h_reg         <= '0;
            sweep_cnt_reg <= '0;
            sweeps_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sweeps_reg    <= sweeps;
                        i_reg         <= '0;
                        j_reg         <= '0;
                        h_reg         <= '0;
                        sweep_cnt_reg <= '0;
                    end
                end
                ST_ACCUM: begin
                    j_reg <= j_reg + LW'(1);
                    if (j_reg != i_reg) begin
                        h_reg <= h_reg + term;
                    end
                end
                ST_UPDATE: begin
                    h_reg <= '0;
                    j_reg <= '0;
                    i_reg <= i_reg + LW'(1);
                    if (i_last) begin
                        sweep_cnt_reg <= sweep_cnt_reg + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Spin vector: bus writes when not busy, sequential updates during a run.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            spins_reg <= '0;
        end else if (spin_we) begin
            spins_reg <= wdata[N-1:0];
        end else if (state_reg == ST_UPDATE) begin
            spins_reg[i_reg] <= new_spin;
        end
    end

    assign spins = spins_reg;

    // Registered readback: sign-extended coupling, zero-extended spins, else zero.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            rdata_reg <= '0;
        end else if ((rd_addr[31:24] == `WEIGHT_ADDR_MASK) && rd_in_range) begin
            rdata_reg <= 32'(weight_mem[{rd_i, rd_j}]);
        end else if (rd_addr[31:24] == `SPIN_ADDR_MASK) begin
            rdata_reg <= 32'(spins_reg);
        end else begin
            rdata_reg <= '0;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_sync_ising_matrix.sv
// Testbench for sync_ising_matrix (N=4, WEIGHT_W=4, default build without
// SYNC_ISING_RANDOM_TIE_EN). A table of register write/read vectors, followed
// by hand-written run sequences for timing and corner cases.

`ifndef WEIGHT_ADDR_MASK
`define WEIGHT_ADDR_MASK 8'h01
`endif
`ifndef SPIN_ADDR_MASK
`define SPIN_ADDR_MASK 8'h02
`endif

module tb_sync_ising_matrix;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam logic [7:0] WMASK = `WEIGHT_ADDR_MASK;
    localparam logic [7:0] SMASK = `SPIN_ADDR_MASK;

    logic          clk = 1'b0;
    logic          axi_rst;
    logic          start;
    logic [15:0]   sweeps;
    logic          busy;
    logic          done;
    logic [N-1:0]  spins;
    logic          wready;
    logic [31:0]   wr_addr;
    logic [31:0]   wdata;
    logic [31:0]   rd_addr;
    logic [31:0]   rdata;

    sync_ising_matrix #(.N(N), .WEIGHT_W(WW)) dut (
        .clk     (clk),
        .axi_rst (axi_rst),
        .start   (start),
        .sweeps  (sweeps),
        .busy    (busy),
        .done    (done),
        .spins   (spins),
        .wready  (wready),
        .wr_addr (wr_addr),
        .wdata   (wdata),
        .rd_addr (rd_addr),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wd;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    function automatic logic [31:0] wa(input int i, input int j);
        return ({WMASK, 24'h0}) | (32'(j) << 13) | (32'(i) << 2);
    endfunction

    function automatic logic [31:0] sa();
        return {SMASK, 24'h0};
    endfunction

    task automatic do_reset();
        axi_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axi_rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wready  = 1'b1;
        wr_addr = a;
        wdata   = d;
        @(posedge clk);
        #1;
        wready  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        rd_addr = a;
        @(posedge clk);
        #1;
        d = rdata;
        rd_addr = '0;
    endtask

    task automatic load_ferro();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i != j) wr(wa(i, j), 32'd1);
            end
        end
    endtask

    // Start a run and sample after every edge. Checks the done edge, that
    // exactly one done pulse occurs, and that busy is high exactly on edges
    // 0..exp_edge-1. It can optionally pulse start or a write at a given edge.
    task automatic run(input string tag, input int s, input int exp_edge,
                       input int restart_edge, input int wr_edge,
                       input logic [31:0] waddr, input logic [31:0] wd);
        int first_done;
        int pulses;
        int busy_err;
        first_done = -1;
        pulses     = 0;
        busy_err   = 0;
        sweeps = 16'(s);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 0; e <= exp_edge + 4; e++) begin
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = e;
            end
            if (busy !== (e < exp_edge)) busy_err++;
            start   = (e == restart_edge);
            wready  = (e == wr_edge);
            wr_addr = waddr;
            wdata   = wd;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        wready = 1'b0;
        check({tag, " done edge"}, 32'(first_done), 32'(exp_edge));
        check({tag, " done pulses"}, 32'(pulses), 32'd1);
        check({tag, " busy window errors"}, 32'(busy_err), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          pulses;

        axi_rst = 1'b1;
        start   = 1'b0;
        sweeps  = '0;
        wready  = 1'b0;
        wr_addr = '0;
        wdata   = '0;
        rd_addr = '0;

        vecs[0]  = '{"J01 after reset",        1'b0, '0,                      32'h0,        wa(0, 1), 32'h0000_0000};
        vecs[1]  = '{"J01 write 3",            1'b1, wa(0, 1),                32'h3,        wa(0, 1), 32'h0000_0003};
        vecs[2]  = '{"J01 write -5",           1'b1, wa(0, 1),                32'hFFFF_FFFB, wa(0, 1), 32'hFFFF_FFFB};
        vecs[3]  = '{"j field out of range",   1'b1, wa(0, 1) | 32'h0000_8000, 32'h7,        wa(0, 1), 32'hFFFF_FFFB};
        vecs[4]  = '{"i field out of range",   1'b1, wa(0, 1) | 32'h0000_0010, 32'h2,        wa(0, 1), 32'hFFFF_FFFB};
        vecs[5]  = '{"wready low ignored",     1'b0, wa(0, 1),                32'h1,        wa(0, 1), 32'hFFFF_FFFB};
        vecs[6]  = '{"J32 write 7",            1'b1, wa(3, 2),                32'h7,        wa(3, 2), 32'h0000_0007};
        vecs[7]  = '{"J23 write -8",           1'b1, wa(2, 3),                32'h8,        wa(2, 3), 32'hFFFF_FFF8};
        vecs[8]  = '{"unmatched mask write",   1'b1, 32'h0300_4008,           32'h1,        wa(3, 2), 32'h0000_0007};
        vecs[9]  = '{"spin write/readback",    1'b1, sa(),                    32'hFFFF_FFFA, sa(),     32'h0000_000A};
        vecs[10] = '{"unmatched read",         1'b0, '0,                      32'h0,        32'h0500_0000, 32'h0000_0000};

        // Reset state
        do_reset();
        check("reset spins", 32'(spins), 32'h0);
        check("reset busy",  32'(busy),  32'h0);
        check("reset done",  32'(done),  32'h0);
        check("reset rdata", rdata,      32'h0);

        // Register read/write table
        for (int k = 0; k < NV; k++) begin
            wready  = vecs[k].do_wr;
            wr_addr = vecs[k].waddr;
            wdata   = vecs[k].wd;
            rd_addr = '0;
            @(posedge clk);
            #1;
            wready  = 1'b0;
            rd_addr = vecs[k].raddr;
            @(posedge clk);
            #1;
            check(vecs[k].name, rdata, vecs[k].exp);
        end
        rd_addr = '0;

        // Reset clears the matrix and the spins
        do_reset();
        rd(wa(3, 2), d);
        check("J32 cleared by reset", d, 32'h0);
        check("spins cleared by reset", 32'(spins), 32'h0);

        // Ferromagnet: every spin aligns with the majority
        load_ferro();
        wr(sa(), 32'h7);
        run("ferro 0111", 1, 20, -1, -1, '0, '0);
        check("ferro 0111 spins", 32'(spins), 32'hF);
        wr(sa(), 32'h1);
        run("ferro 0001", 1, 20, -1, -1, '0, '0);
        check("ferro 0001 spins", 32'(spins), 32'h0);

        // A weight write during busy is dropped
        wr(sa(), 32'h7);
        run("busy write", 1, 20, -1, 5, wa(1, 0), 32'h5);
        rd(wa(1, 0), d);
        check("J10 unchanged by busy write", d, 32'h1);
        check("busy write spins", 32'(spins), 32'hF);

        // A second start mid-run is ignored
        wr(sa(), 32'h1);
        run("restart", 1, 20, 8, -1, '0, '0);
        check("restart spins", 32'(spins), 32'h0);

        // S=0 completes immediately and leaves the spins untouched
        wr(sa(), 32'h5);
        run("S=0", 0, 0, -1, -1, '0, '0);
        check("S=0 spins", 32'(spins), 32'h5);

        // All-zero couplings: every h is 0, so the tie keeps each spin
        do_reset();
        wr(sa(), 32'hA);
        run("tie", 2, 40, -1, -1, '0, '0);
        check("tie spins", 32'(spins), 32'hA);

        // Reset mid-run
        load_ferro();
        wr(sa(), 32'h7);
        sweeps = 16'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
        end
        check("busy before mid-run reset", 32'(busy), 32'h1);
        axi_rst = 1'b1;
        @(posedge clk);
        #1;
        axi_rst = 1'b0;
        check("mid-run reset busy",  32'(busy),  32'h0);
        check("mid-run reset spins", 32'(spins), 32'h0);
        check("mid-run reset done",  32'(done),  32'h0);
        pulses = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("mid-run reset no done pulse", 32'(pulses), 32'h0);
        rd(wa(0, 1), d);
        check("mid-run reset J01 cleared", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
